// File: rtl/e203_dtcm_icb_arbt2_if.sv
// ICB bus bundle shared by the DTCM arbiter ports: command channel plus response channel.
// master drives commands and consumes responses; slave is the opposite side.
interface e203_dtcm_icb_arbt2_if #(
    parameter int unsigned AW = 16,
    parameter int unsigned DW = 32,
    parameter int unsigned MW = 4
) ();

    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic          cmd_read;
    logic [DW-1:0] cmd_wdata;
    logic [MW-1:0] cmd_wmask;

    logic          rsp_valid;
    logic          rsp_ready;
    logic          rsp_err;
    logic [DW-1:0] rsp_rdata;

    modport master (
        output cmd_valid,
        output cmd_addr,
        output cmd_read,
        output cmd_wdata,
        output cmd_wmask,
        input  cmd_ready,
        input  rsp_valid,
        input  rsp_err,
        input  rsp_rdata,
        output rsp_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_addr,
        input  cmd_read,
        input  cmd_wdata,
        input  cmd_wmask,
        output cmd_ready,
        output rsp_valid,
        output rsp_err,
        output rsp_rdata,
        input  rsp_ready
    );

endinterface

// File: rtl/e203_dtcm_icb_arbt2.sv
// Two-requester ICB arbiter (LSU priority) in front of the DTCM SRAM controller; a source-ID
// FIFO routes responses back. Optional anti-starvation for ext: define E203_DTCM_ARBT_STARVE_EN.
module e203_dtcm_icb_arbt2 #(
    parameter int unsigned AW         = 16,
    parameter int unsigned DW         = 32,
    parameter int unsigned MW         = 4,
    parameter int unsigned OUTS_NUM   = 1,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    e203_dtcm_icb_arbt2_if.slave         lsu_icb,
    e203_dtcm_icb_arbt2_if.slave         ext_icb,
    e203_dtcm_icb_arbt2_if.master        o_icb,
    output logic                         arbt_active
);

    localparam int unsigned PtrW = (OUTS_NUM > 1) ? $clog2(OUTS_NUM) : 1;
    localparam int unsigned CntW = $clog2(OUTS_NUM + 1);
    localparam int unsigned SlotN = 1 << PtrW;

    logic            lsu_valid;
    logic            ext_valid;
    logic            force_ext;
    logic            sel_ext_raw;
    logic            sel_ext;
    logic            cmd_hs;
    logic            push;
    logic            pop;
    logic            fifo_full;
    logic            fifo_empty;
    logic            head;

    logic [AW-1:0]   sel_addr;
    logic            sel_read;
    logic [DW-1:0]   sel_wdata;
    logic [MW-1:0]   sel_wmask;

    logic            lock_q;
    logic            lock_d;
    logic            lock_sel_q;

    logic [SlotN-1:0] src_q;
    logic [PtrW-1:0]  wr_ptr_q;
    logic [PtrW-1:0]  rd_ptr_q;
    logic [CntW-1:0]  cnt_q;
    logic [CntW-1:0]  cnt_d;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        if (p == PtrW'(OUTS_NUM - 1)) begin
            return '0;
        end
        return p + PtrW'(1);
    endfunction

    assign lsu_valid = lsu_icb.cmd_valid;
    assign ext_valid = ext_icb.cmd_valid;

    // ---------------------------------------------------------------------------------------
    // Grant selection and command mux
    // ---------------------------------------------------------------------------------------
    always_comb begin
        sel_ext_raw = ext_valid & (~lsu_valid | force_ext);
        // A stalled grant keeps its source so a forced ext grant cannot be withdrawn.
        sel_ext     = lock_q ? lock_sel_q : sel_ext_raw;
    end

    always_comb begin
        if (sel_ext) begin
            sel_addr  = ext_icb.cmd_addr;
            sel_read  = ext_icb.cmd_read;
            sel_wdata = ext_icb.cmd_wdata;
            sel_wmask = ext_icb.cmd_wmask;
        end else begin
            sel_addr  = lsu_icb.cmd_addr;
            sel_read  = lsu_icb.cmd_read;
            sel_wdata = lsu_icb.cmd_wdata;
            sel_wmask = lsu_icb.cmd_wmask;
        end
    end

    always_comb begin
        o_icb.cmd_valid   = (lsu_valid | ext_valid) & ~fifo_full;
        o_icb.cmd_addr    = sel_addr;
        o_icb.cmd_read    = sel_read;
        o_icb.cmd_wdata   = sel_wdata;
        o_icb.cmd_wmask   = sel_wmask;
        lsu_icb.cmd_ready = o_icb.cmd_ready & ~fifo_full & ~sel_ext;
        ext_icb.cmd_ready = o_icb.cmd_ready & ~fifo_full & sel_ext;
        cmd_hs            = o_icb.cmd_valid & o_icb.cmd_ready;
        lock_d            = o_icb.cmd_valid & ~o_icb.cmd_ready;
    end

    // ---------------------------------------------------------------------------------------
    // Source-ID FIFO and response routing
    // ---------------------------------------------------------------------------------------
    always_comb begin
        fifo_full  = (cnt_q == CntW'(OUTS_NUM));
        fifo_empty = (cnt_q == '0);
        head       = src_q[rd_ptr_q];
        push       = cmd_hs;
        pop        = o_icb.rsp_valid & o_icb.rsp_ready & ~fifo_empty;

        cnt_d = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + CntW'(1);
        end else if (pop && !push) begin
            cnt_d = cnt_q - CntW'(1);
        end
    end

    always_comb begin
        lsu_icb.rsp_valid = o_icb.rsp_valid & ~fifo_empty & ~head;
        ext_icb.rsp_valid = o_icb.rsp_valid & ~fifo_empty & head;
        lsu_icb.rsp_err   = o_icb.rsp_err;
        ext_icb.rsp_err   = o_icb.rsp_err;
        lsu_icb.rsp_rdata = o_icb.rsp_rdata;
        ext_icb.rsp_rdata = o_icb.rsp_rdata;
        // Unsolicited responses (e.g. in flight across a reset) are swallowed.
        if (fifo_empty) begin
            o_icb.rsp_ready = 1'b1;
        end else if (head) begin
            o_icb.rsp_ready = ext_icb.rsp_ready;
        end else begin
            o_icb.rsp_ready = lsu_icb.rsp_ready;
        end
        arbt_active = lsu_valid | ext_valid | ~fifo_empty;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            lock_q     <= 1'b0;
            lock_sel_q <= 1'b0;
        end else begin
            if (push) begin
                src_q[wr_ptr_q] <= sel_ext;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            cnt_q      <= cnt_d;
            lock_q     <= lock_d;
            lock_sel_q <= sel_ext;
        end
    end

    // ---------------------------------------------------------------------------------------
    // Anti-starvation
    // ---------------------------------------------------------------------------------------
`ifdef E203_DTCM_ARBT_STARVE_EN
    localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

    logic [3:0] starve_cnt_q;
    logic [3:0] starve_cnt_d;

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (cmd_hs && sel_ext) begin
            starve_cnt_d = '0;
        end else if (cmd_hs && ext_valid && (starve_cnt_q != StarveMax)) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end
        force_ext = (starve_cnt_q == StarveMax);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`else
    assign force_ext = 1'b0;
`endif

`ifndef SYNTHESIS
    always @(posedge clk) begin
        assert (OUTS_NUM >= 1 && OUTS_NUM <= 4 && STARVE_MAX >= 2 && STARVE_MAX <= 15)
            else $error("e203_dtcm_icb_arbt2: parameter out of range");
        if (rst_n) begin
            assert (!(o_icb.rsp_valid && fifo_empty))
                else $warning("e203_dtcm_icb_arbt2: response with no outstanding command dropped");
        end
    end
`endif

endmodule

// File: tb/tb_e203_dtcm_icb_arbt2.sv
// Scoreboard bench for e203_dtcm_icb_arbt2: directed command queues per requester, a
// one-cycle SRAM responder, and monitors that pop expected grants/responses.
module tb_e203_dtcm_icb_arbt2;

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 32;
    localparam int unsigned MW = 4;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          read;
        logic [DW-1:0] wdata;
        logic [MW-1:0] wmask;
    } cmd_t;

    typedef struct packed {
        logic          err;
        logic [DW-1:0] rdata;
    } rsp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic arbt_active;

    always #5 clk = ~clk;

    e203_dtcm_icb_arbt2_if #(.AW(AW), .DW(DW), .MW(MW)) lsu_icb ();
    e203_dtcm_icb_arbt2_if #(.AW(AW), .DW(DW), .MW(MW)) ext_icb ();
    e203_dtcm_icb_arbt2_if #(.AW(AW), .DW(DW), .MW(MW)) o_icb ();

    e203_dtcm_icb_arbt2 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .lsu_icb    (lsu_icb),
        .ext_icb    (ext_icb),
        .o_icb      (o_icb),
        .arbt_active(arbt_active)
    );

    cmd_t lsu_cmds[$];
    cmd_t ext_cmds[$];
    cmd_t grant_exp[$];
    rsp_t lsu_exp[$];
    rsp_t ext_exp[$];
    rsp_t sram_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic cmd_t mk_cmd(input logic src, input logic [15:0] a, input logic rd);
        cmd_t c;
        c.addr  = a;
        c.read  = rd;
        c.wdata = {src, 15'h0, a};
        c.wmask = rd ? 4'h0 : 4'hf;
        return c;
    endfunction

    task automatic issue(input logic src, input logic [15:0] a, input logic rd,
                         input logic [31:0] rdata, input logic err);
        cmd_t c;
        rsp_t r;
        c       = mk_cmd(src, a, rd);
        r.err   = err;
        r.rdata = rdata;
        if (src) begin
            ext_cmds.push_back(c);
            ext_exp.push_back(r);
        end else begin
            lsu_cmds.push_back(c);
            lsu_exp.push_back(r);
        end
    endtask

    task automatic expect_grant(input logic src, input logic [15:0] a, input logic rd);
        grant_exp.push_back(mk_cmd(src, a, rd));
    endtask

    task automatic wait_idle(input string name);
        logic idle;
        idle = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            idle = (lsu_cmds.size() == 0) && (ext_cmds.size() == 0) && (grant_exp.size() == 0) &&
                   (lsu_exp.size() == 0) && (ext_exp.size() == 0) && (sram_q.size() == 0);
            if (idle) break;
        end
        check(name, 64'(idle), 64'd1);
    endtask

    // LSU requester driver
    initial begin
        logic hs;
        lsu_icb.cmd_valid = 1'b0;
        lsu_icb.cmd_addr  = '0;
        lsu_icb.cmd_read  = 1'b0;
        lsu_icb.cmd_wdata = '0;
        lsu_icb.cmd_wmask = '0;
        forever begin
            @(negedge clk);
            hs = lsu_icb.cmd_valid & lsu_icb.cmd_ready;
            @(posedge clk);
            #1;
            if (hs) void'(lsu_cmds.pop_front());
            lsu_icb.cmd_valid = (lsu_cmds.size() > 0);
            if (lsu_cmds.size() > 0) begin
                lsu_icb.cmd_addr  = lsu_cmds[0].addr;
                lsu_icb.cmd_read  = lsu_cmds[0].read;
                lsu_icb.cmd_wdata = lsu_cmds[0].wdata;
                lsu_icb.cmd_wmask = lsu_cmds[0].wmask;
            end
        end
    end

    // ext requester driver
    initial begin
        logic hs;
        ext_icb.cmd_valid = 1'b0;
        ext_icb.cmd_addr  = '0;
        ext_icb.cmd_read  = 1'b0;
        ext_icb.cmd_wdata = '0;
        ext_icb.cmd_wmask = '0;
        forever begin
            @(negedge clk);
            hs = ext_icb.cmd_valid & ext_icb.cmd_ready;
            @(posedge clk);
            #1;
            if (hs) void'(ext_cmds.pop_front());
            ext_icb.cmd_valid = (ext_cmds.size() > 0);
            if (ext_cmds.size() > 0) begin
                ext_icb.cmd_addr  = ext_cmds[0].addr;
                ext_icb.cmd_read  = ext_cmds[0].read;
                ext_icb.cmd_wdata = ext_cmds[0].wdata;
                ext_icb.cmd_wmask = ext_cmds[0].wmask;
            end
        end
    end

    // SRAM responder: answers one cycle after each accepted command
    initial begin
        logic cmd_hs;
        logic rsp_hs;
        cmd_t c;
        rsp_t r;
        o_icb.rsp_valid = 1'b0;
        o_icb.rsp_err   = 1'b0;
        o_icb.rsp_rdata = '0;
        forever begin
            @(negedge clk);
            cmd_hs  = o_icb.cmd_valid & o_icb.cmd_ready;
            rsp_hs  = o_icb.rsp_valid & o_icb.rsp_ready;
            c.addr  = o_icb.cmd_addr;
            c.read  = o_icb.cmd_read;
            c.wdata = o_icb.cmd_wdata;
            c.wmask = o_icb.cmd_wmask;
            @(posedge clk);
            #1;
            if (rsp_hs) void'(sram_q.pop_front());
            if (cmd_hs) begin
                r.rdata = c.read ? {c.addr, 16'hBEEF} : 32'h0;
                r.err   = c.addr[0];
                sram_q.push_back(r);
            end
            o_icb.rsp_valid = (sram_q.size() > 0);
            if (sram_q.size() > 0) begin
                o_icb.rsp_err   = sram_q[0].err;
                o_icb.rsp_rdata = sram_q[0].rdata;
            end
        end
    end

    // Command-side monitor: grant order, payload, and which requester saw ready
    initial begin
        cmd_t e;
        cmd_t a;
        forever begin
            @(negedge clk);
            if (o_icb.cmd_valid && o_icb.cmd_ready) begin
                a.addr  = o_icb.cmd_addr;
                a.read  = o_icb.cmd_read;
                a.wdata = o_icb.cmd_wdata;
                a.wmask = o_icb.cmd_wmask;
                if (grant_exp.size() == 0) begin
                    check("grant_unexpected", 64'(a), 64'd0);
                end else begin
                    e = grant_exp.pop_front();
                    check("grant_cmd", 64'(a), 64'(e));
                    check("grant_ready", {62'd0, lsu_icb.cmd_ready, ext_icb.cmd_ready},
                          e.wdata[31] ? 64'd1 : 64'd2);
                end
            end
        end
    end

    // Response-side monitor
    initial begin
        rsp_t e;
        forever begin
            @(negedge clk);
            if (lsu_icb.rsp_valid || ext_icb.rsp_valid) begin
                check("rsp_exclusive", 64'(lsu_icb.rsp_valid & ext_icb.rsp_valid), 64'd0);
            end
            if (lsu_icb.rsp_valid && lsu_icb.rsp_ready) begin
                if (lsu_exp.size() == 0) begin
                    check("lsu_rsp_unexpected", 64'd1, 64'd0);
                end else begin
                    e = lsu_exp.pop_front();
                    check("lsu_rsp", 64'({lsu_icb.rsp_err, lsu_icb.rsp_rdata}), 64'(e));
                end
            end
            if (ext_icb.rsp_valid && ext_icb.rsp_ready) begin
                if (ext_exp.size() == 0) begin
                    check("ext_rsp_unexpected", 64'd1, 64'd0);
                end else begin
                    e = ext_exp.pop_front();
                    check("ext_rsp", 64'({ext_icb.rsp_err, ext_icb.rsp_rdata}), 64'(e));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic       ord [8];
        logic       got;
        int         li;
        int         ei;

        rst_n             = 1'b0;
        o_icb.cmd_ready   = 1'b1;
        lsu_icb.rsp_ready = 1'b1;
        ext_icb.rsp_ready = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_o_cmd_valid", 64'(o_icb.cmd_valid), 64'd0);
        check("rst_arbt_active", 64'(arbt_active), 64'd0);
        check("rst_lsu_rsp_valid", 64'(lsu_icb.rsp_valid), 64'd0);
        check("rst_ext_rsp_valid", 64'(ext_icb.rsp_valid), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Both valid: LSU first, ext only after LSU response handshake
        @(negedge clk);
        issue(1'b0, 16'h1000, 1'b1, 32'h1000BEEF, 1'b0);
        issue(1'b1, 16'h2002, 1'b0, 32'h0, 1'b0);
        expect_grant(1'b0, 16'h1000, 1'b1);
        expect_grant(1'b1, 16'h2002, 1'b0);
        @(negedge clk);
        check("both_lsu_ready", 64'(lsu_icb.cmd_ready), 64'd1);
        check("both_ext_ready", 64'(ext_icb.cmd_ready), 64'd0);
        check("both_active", 64'(arbt_active), 64'd1);
        @(negedge clk);
        check("full_o_cmd_valid", 64'(o_icb.cmd_valid), 64'd0);
        check("full_lsu_rsp_valid", 64'(lsu_icb.rsp_valid), 64'd1);
        @(negedge clk);
        check("second_ext_ready", 64'(ext_icb.cmd_ready), 64'd1);
        wait_idle("idle_both");

        // LSU read DEADBEEF then ext write
        @(negedge clk);
        issue(1'b0, 16'hDEAD, 1'b1, 32'hDEADBEEF, 1'b1);
        issue(1'b1, 16'h2001, 1'b0, 32'h0, 1'b1);
        expect_grant(1'b0, 16'hDEAD, 1'b1);
        expect_grant(1'b1, 16'h2001, 1'b0);
        wait_idle("idle_route");

        // Continuous contention: grant order depends on anti-starvation
`ifdef E203_DTCM_ARBT_STARVE_EN
        ord = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
`else
        ord = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
`endif
        @(negedge clk);
        for (int i = 0; i < 6; i++) issue(1'b0, 16'h1100 + 16'(i * 2), 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 2; i++) issue(1'b1, 16'h2200 + 16'(i * 2), 1'b0, 32'h0, 1'b0);
        li = 0;
        ei = 0;
        for (int k = 0; k < 8; k++) begin
            if (ord[k]) begin
                expect_grant(1'b1, 16'h2200 + 16'(ei * 2), 1'b0);
                ei++;
            end else begin
                expect_grant(1'b0, 16'h1100 + 16'(li * 2), 1'b0);
                li++;
            end
        end
        wait_idle("idle_starve");

        // A stalled ext grant holds its selection when LSU arrives
        @(posedge clk);
        #1 o_icb.cmd_ready = 1'b0;
        @(negedge clk);
        issue(1'b1, 16'h2300, 1'b0, 32'h0, 1'b0);
        expect_grant(1'b1, 16'h2300, 1'b0);
        expect_grant(1'b0, 16'h1300, 1'b0);
        @(negedge clk);
        check("lock_o_cmd_valid", 64'(o_icb.cmd_valid), 64'd1);
        issue(1'b0, 16'h1300, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        check("lock_hold_addr", 64'(o_icb.cmd_addr), 64'h2300);
        @(posedge clk);
        #1 o_icb.cmd_ready = 1'b1;
        wait_idle("idle_lock");

        // Response back-pressure with FIFO full blocks further commands
        @(posedge clk);
        #1 lsu_icb.rsp_ready = 1'b0;
        @(negedge clk);
        issue(1'b0, 16'h1400, 1'b1, 32'h1400BEEF, 1'b0);
        issue(1'b1, 16'h2400, 1'b0, 32'h0, 1'b0);
        expect_grant(1'b0, 16'h1400, 1'b1);
        expect_grant(1'b1, 16'h2400, 1'b0);
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (lsu_icb.rsp_valid) begin
                got = 1'b1;
                break;
            end
        end
        check("hold_rsp_seen", 64'(got), 64'd1);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            check("hold_o_rsp_ready", 64'(o_icb.rsp_ready), 64'd0);
            check("hold_o_cmd_valid", 64'(o_icb.cmd_valid), 64'd0);
        end
        @(posedge clk);
        #1 lsu_icb.rsp_ready = 1'b1;
        wait_idle("idle_hold");

        // Reset with one transaction outstanding; in-flight response must be dropped
        @(posedge clk);
        #1 lsu_icb.rsp_ready = 1'b0;
        @(negedge clk);
        issue(1'b0, 16'h1500, 1'b1, 32'h1500BEEF, 1'b0);
        expect_grant(1'b0, 16'h1500, 1'b1);
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (lsu_icb.rsp_valid) begin
                got = 1'b1;
                break;
            end
        end
        check("rst_txn_outstanding", 64'(got), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_arbt_active", 64'(arbt_active), 64'd0);
        check("midrst_lsu_rsp_valid", 64'(lsu_icb.rsp_valid), 64'd0);
        lsu_exp.delete();
        #1 rst_n = 1'b1;
        #1;
        check("postrst_lsu_rsp_valid", 64'(lsu_icb.rsp_valid), 64'd0);
        check("postrst_ext_rsp_valid", 64'(ext_icb.rsp_valid), 64'd0);
        check("postrst_o_rsp_ready", 64'(o_icb.rsp_ready), 64'd1);
        @(posedge clk);
        #1 lsu_icb.rsp_ready = 1'b1;
        @(negedge clk);
        check("postrst_lsu_rsp_valid2", 64'(lsu_icb.rsp_valid), 64'd0);
        @(negedge clk);
        check("postrst_arbt_active", 64'(arbt_active), 64'd0);
        wait_idle("idle_final");

        check("scoreboard_drained",
              64'(lsu_exp.size() + ext_exp.size() + grant_exp.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
